// File: rtl/pipelined_shifter_if.sv
// Operation/result handshake bundle for pipelined_shifter.
// slave is the shifter side; master is the producer/consumer side.
interface pipelined_shifter_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int STAGES = $clog2(WIDTH);
   localparam int OCC_W  = $clog2(STAGES) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [31:0]      in_shamt;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic [OCC_W-1:0] occupancy;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, occupancy
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Purpose: SLL/SRL/SRA/ROR barrel shifter, one register stage per shift-amount bit.
// Latency: log2(WIDTH) stages; the accepting edge loads stage 0, the last stage is the output.
// Backpressure: a held result freezes every stage and drops in_ready; bubbles are not compacted.
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   pipelined_shifter_if.slave  bus
);
   localparam int STAGES = $clog2(WIDTH);
   localparam int OCC_W  = $clog2(STAGES) + 1;
   localparam int LAST   = STAGES - 1;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;

   typedef struct packed {
      logic              vld;
      logic [1:0]        mode;
      logic [TAG_W-1:0]  tag;
      logic              sign;
      logic              ovf;
      logic [STAGES-1:0] shamt;
      logic [WIDTH-1:0]  dat;
   } stageT;

   stageT            stg [STAGES];
   stageT            nxt [STAGES];
   stageT            entry;
   stageT            src;
   logic [OCC_W-1:0] occ;
   logic             stall;
   logic             inReady;
   logic             inXfer;
   logic             outXfer;

   function automatic logic [WIDTH-1:0] stepShift(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input logic sign,
                                                  input int s);
      logic signed [WIDTH:0] ext;
      ext = '0;
      case (mode)
         MODE_SLL: stepShift = d << s;
         MODE_SRL: stepShift = d >> s;
         MODE_SRA: begin
            ext       = $signed({sign, d}) >>> s;
            stepShift = ext[WIDTH-1:0];
         end
         default:  stepShift = (d >> s) | (d << (WIDTH - s));
      endcase
   endfunction

   assign stall   = stg[LAST].vld && !bus.out_ready;
   assign inReady = !stall;
   assign inXfer  = bus.in_valid && inReady;
   assign outXfer = stg[LAST].vld && bus.out_ready;

   always_comb begin
      entry       = '0;
      entry.vld   = bus.in_valid;
      entry.mode  = bus.in_mode;
      entry.tag   = bus.in_tag;
      entry.sign  = bus.in_data[WIDTH-1];
      entry.ovf   = |bus.in_shamt[31:STAGES];
      entry.shamt = bus.in_shamt[STAGES-1:0];
      entry.dat   = bus.in_data;
      src         = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) src = entry;
         else        src = stg[k-1];
         nxt[k] = src;
         if (src.shamt[k]) nxt[k].dat = stepShift(src.dat, src.mode, src.sign, 1 << k);
      end
      // Out-of-range amounts saturate at the final stage; rotate just wraps.
      if (nxt[LAST].ovf) begin
         if (nxt[LAST].mode == MODE_SRA)
            nxt[LAST].dat = {WIDTH{nxt[LAST].sign}};
         else if (nxt[LAST].mode == MODE_SLL || nxt[LAST].mode == MODE_SRL)
            nxt[LAST].dat = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) stg[k] <= '0;
         occ <= '0;
      end else begin
         if (!stall) begin
            for (int k = 0; k < STAGES; k++) stg[k] <= nxt[k];
         end
         case ({inXfer, outXfer})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = stg[LAST].vld;
   assign bus.out_data  = stg[LAST].dat;
   assign bus.out_tag   = stg[LAST].tag;
   assign bus.occupancy = occ;
endmodule
